// File: rtl/float_to_uint16.sv
// float_to_uint16: iterative IEEE-754 single-precision to uint16 converter.
// The mantissa is right-shifted one bit per cycle, so latency depends on the
// exponent. Results are clamped or zeroed for out-of-range, negative and NaN
// inputs, each reported through its own flag.
//
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   in_float          IEEE-754 single, sampled only on the accepting edge
//   in_valid/ready    input handshake (ready only while idle)
//   out_uint          converted result, held while out_valid
//   out_valid/ready   output handshake
//   out_saturated     result clamped to 65535
//   out_negative      input negative and nonzero, result forced to 0
//   out_nan           input NaN, result forced to 0
module float_to_uint16 #(
    parameter bit ROUND_NEAREST = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] in_float,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_uint,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_saturated,
    output logic        out_negative,
    output logic        out_nan
);

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned ACC_W  = 24;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned OUT_W  = 16;
    localparam int unsigned SUM_W  = 17;

    // Exponent thresholds in biased form: e = exp - 127
    localparam logic [EXP_W-1:0] EXP_MAX    = 8'd255;
    localparam logic [EXP_W-1:0] EXP_MIN_OK = 8'd126;  // e = -1
    localparam logic [EXP_W-1:0] EXP_SAT    = 8'd143;  // e = 16
    localparam logic [EXP_W-1:0] EXP_CNT0   = 8'd150;  // count = 23 - e = 150 - exp

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0]    uint_d;
    logic                sat_d, neg_d, nan_d;

    logic                f_sign;
    logic [EXP_W-1:0]    f_exp;
    logic [FRAC_W-1:0]   f_frac;
    logic                round_bit;
    logic [SUM_W-1:0]    r_sum;

    // Field split of the input word
    always_comb begin
        f_sign = in_float[31];
        f_exp  = in_float[30:23];
        f_frac = in_float[22:0];
    end

    // Final rounding step: at count=1 acc holds at most 17 significant bits
    always_comb begin
        round_bit = ROUND_NEAREST ? acc_q[0] : 1'b0;
        r_sum     = SUM_W'(acc_q[OUT_W:1]) + SUM_W'(round_bit);
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        uint_d  = out_uint;
        sat_d   = out_saturated;
        neg_d   = out_negative;
        nan_d   = out_nan;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = DONE;
                    if (f_exp == EXP_MAX && f_frac != '0) begin
                        uint_d = '0;
                        sat_d  = 1'b0;
                        neg_d  = 1'b0;
                        nan_d  = 1'b1;
                    end else if (f_sign) begin
                        // -0.0 converts silently; any other negative is flagged
                        uint_d = '0;
                        sat_d  = 1'b0;
                        neg_d  = |in_float[30:0];
                        nan_d  = 1'b0;
                    end else if (f_exp < EXP_MIN_OK) begin
                        // zero, denormal, or below 0.5
                        uint_d = '0;
                        sat_d  = 1'b0;
                        neg_d  = 1'b0;
                        nan_d  = 1'b0;
                    end else if (f_exp >= EXP_SAT) begin
                        // also covers +inf
                        uint_d = '1;
                        sat_d  = 1'b1;
                        neg_d  = 1'b0;
                        nan_d  = 1'b0;
                    end else begin
                        acc_d   = {1'b1, f_frac};
                        cnt_d   = CNT_W'(EXP_CNT0 - f_exp);
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                if (cnt_q > CNT_W'(1)) begin
                    acc_d = acc_q >> 1;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    neg_d   = 1'b0;
                    nan_d   = 1'b0;
                    state_d = DONE;
                    if (r_sum[OUT_W]) begin
                        uint_d = '1;
                        sat_d  = 1'b1;
                    end else begin
                        uint_d = r_sum[OUT_W-1:0];
                        sat_d  = 1'b0;
                    end
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            out_uint      <= '0;
            out_saturated <= 1'b0;
            out_negative  <= 1'b0;
            out_nan       <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            in_ready      <= (state_d == IDLE);
            out_valid     <= (state_d == DONE);
            out_uint      <= uint_d;
            out_saturated <= sat_d;
            out_negative  <= neg_d;
            out_nan       <= nan_d;
        end
    end

endmodule

// File: tb/tb_float_to_uint16.sv
// Scoreboard bench for float_to_uint16: directed vectors with hand-computed
// results, backpressure hold, and reset in the middle of a conversion.
module tb_float_to_uint16;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] in_float;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_uint;
    logic        out_valid;
    logic        out_ready;
    logic        out_saturated;
    logic        out_negative;
    logic        out_nan;

    float_to_uint16 #(.ROUND_NEAREST(1'b1)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .in_float      (in_float),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_uint      (out_uint),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_saturated (out_saturated),
        .out_negative  (out_negative),
        .out_nan       (out_nan)
    );

    // flags packed as {saturated, negative, nan}
    typedef struct {
        logic [15:0] val;
        logic [2:0]  flags;
        int          lat;
        int          acc_cyc;
    } exp_t;

    typedef struct {
        logic [31:0] f;
        logic [15:0] val;
        logic [2:0]  flags;
        int          lat;
    } vec_t;

    localparam int NV = 19;

    exp_t sb[$];
    exp_t m_e;
    vec_t vecs [NV];

    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   rise_cyc = 0;
    logic mon_seen = 1'b0;
    logic stale_watch = 1'b0;
    logic stale_seen = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    // Monitor: pops expectations whenever a result is consumed
    always @(negedge clk) begin
        if (!resetn) begin
            mon_seen = 1'b0;
        end else begin
            if (out_valid && !mon_seen) begin
                mon_seen = 1'b1;
                rise_cyc = cyc;
            end
            if (stale_watch && out_valid) stale_seen = 1'b1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'(out_uint), 32'hFFFF_FFFF);
                end else begin
                    m_e = sb.pop_front();
                    chk("value", 32'(out_uint), 32'(m_e.val));
                    chk("flags", 32'({out_saturated, out_negative, out_nan}), 32'(m_e.flags));
                    chk("latency", 32'(rise_cyc - m_e.acc_cyc + 1), 32'(m_e.lat));
                end
                mon_seen = 1'b0;
            end
        end
    end

    task automatic send(input logic [31:0] f, input logic [15:0] v,
                        input logic [2:0] fl, input int lat);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_float = f;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_float = $urandom;
        sb.push_back('{v, fl, lat, cyc});
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        int   t;
        logic hold_bad;

        vecs = '{
            '{32'h449CA000, 16'd1253,  3'b000, 14},  // 1253.0
            '{32'h423E0000, 16'd48,    3'b000, 19},  // 47.5 rounds up
            '{32'h3F000000, 16'd1,     3'b000, 25},  // 0.5, e=-1
            '{32'h3EFAE148, 16'd0,     3'b000, 1},   // 0.49, e=-2
            '{32'h4788B800, 16'hFFFF,  3'b100, 1},   // 70000.0
            '{32'h477FFFC0, 16'hFFFF,  3'b100, 9},   // 65535.75 rounding overflow
            '{32'h477FFF00, 16'hFFFF,  3'b000, 9},   // 65535.0 exact
            '{32'hC0400000, 16'd0,     3'b010, 1},   // -3.0
            '{32'h7FC00000, 16'd0,     3'b001, 1},   // NaN
            '{32'h80000000, 16'd0,     3'b000, 1},   // -0.0
            '{32'h7F800000, 16'hFFFF,  3'b100, 1},   // +inf
            '{32'hFF800000, 16'd0,     3'b010, 1},   // -inf
            '{32'h3F800000, 16'd1,     3'b000, 24},  // 1.0
            '{32'h3FC00000, 16'd2,     3'b000, 24},  // 1.5 tie away
            '{32'h40200000, 16'd3,     3'b000, 23},  // 2.5 tie away
            '{32'h00000001, 16'd0,     3'b000, 1},   // +denormal
            '{32'h80000001, 16'd0,     3'b010, 1},   // -denormal
            '{32'hFFC00000, 16'd0,     3'b001, 1},   // negative NaN
            '{32'h00000000, 16'd0,     3'b000, 1}    // +0.0
        };

        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_float  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_uint",  32'(out_uint),  32'd0);
        chk("reset_flags", 32'({out_saturated, out_negative, out_nan}), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            send(vecs[i].f, vecs[i].val, vecs[i].flags, vecs[i].lat);
            drain();
        end

        // Backpressure: result held, in_ready low, inputs ignored
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(32'h44284000, 16'd673, 3'b000, 15);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("bp_valid_rise", 32'(out_valid), 32'd1);
        hold_bad = 1'b0;
        in_float = 32'h3F800000;
        in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!out_valid || in_ready || out_uint !== 16'd673) hold_bad = 1'b1;
        end
        in_valid = 1'b0;
        chk("bp_hold", 32'(hold_bad), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_in_ready",  32'(in_ready),  32'd1);
        chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
        drain();

        // Leave saturated flags set so reset clearing is visible
        send(32'h7F800000, 16'hFFFF, 3'b100, 1);
        drain();

        // Reset five edges into a conversion
        send(32'h449CA000, 16'd1253, 3'b000, 14);
        repeat (4) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        sb.delete();
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_uint",  32'(out_uint),  32'd0);
        chk("rst_flags", 32'({out_saturated, out_negative, out_nan}), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        stale_seen  = 1'b0;
        stale_watch = 1'b1;
        repeat (30) @(negedge clk);
        stale_watch = 1'b0;
        chk("no_stale_valid", 32'(stale_seen), 32'd0);

        send(32'h449CA000, 16'd1253, 3'b000, 14);
        drain();
        send(32'h423E0000, 16'd48, 3'b000, 19);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/float_to_uint16.md
# float_to_uint16

Iterative IEEE-754 single-precision to 16-bit unsigned integer converter for the thermal-camera pixel path. Floats computed per pixel (temperature and calibration results) are turned back into uint16 values for frame buffering and display scaling. Conversion uses a one-bit-per-cycle right shifter rather than a barrel shifter, to save LUTs, so latency depends on the exponent. Valid/ready handshakes sit on both sides.

## Interface
- `ROUND_NEAREST`, default 1. 1: round to nearest, ties away from zero. 0: truncate.
- `clk`  in  1  system clock
- `resetn`  in  1  asynchronous, active-low reset
- `in_float`  in  32  IEEE-754 single; sampled only on the accepting edge
- `in_valid`  in  1  input word available
- `in_ready`  out  1  block idle and able to accept
- `out_uint`  out  16  converted result
- `out_valid`  out  1  result held and valid
- `out_ready`  in  1  downstream consumes the result
- `out_saturated`  out  1  result clamped to 65535 (too large or +inf)
- `out_negative`  out  1  input was negative and nonzero; result forced to 0
- `out_nan`  out  1  input was NaN; result forced to 0

## Operation
- States:
  - IDLE: `in_ready`=1.
  - SHIFT: `in_ready`=0, `out_valid`=0.
  - DONE: `out_valid`=1, `in_ready`=0.
- Accept: in IDLE, `in_valid`&`in_ready` at an edge captures `in_float` and classifies it. Define e = exp − 127 and m = {1, frac} (24 bits).
- Special cases go straight to DONE. Priority is top to bottom:
  - exp=255 with frac≠0 → 0, `out_nan`.
  - sign=1 → 0, with `out_negative` set only if the magnitude is nonzero. −0.0 gives 0 with no flag.
  - exp=0 (zero or denormal) → 0.
  - e < −1 → 0.
  - e ≥ 16, or +inf → 65535, `out_saturated`.
- Normal case, −1 ≤ e ≤ 15: load acc=m and count=23−e (range 8..24), then go to SHIFT.
- SHIFT, each edge with count>1: acc ← acc>>1, count ← count−1.
- SHIFT, edge with count=1:
  - With rounding: r = (acc>>1) + (ROUND_NEAREST ? acc[0] : 0).
  - If r > 65535, set `out_uint`=65535 and `out_saturated`. Otherwise `out_uint`=r[15:0].
  - Go to DONE.
- Flags are updated only when a result is loaded. Non-applicable flags are cleared at that point.
- DONE: `out_uint` and all flags are held stable until `out_valid`&`out_ready`, then the block returns to IDLE. No new input is accepted in the same cycle.
- Changes on `in_float` and `in_valid` outside IDLE are ignored.
- Arithmetic: acc is 24 bits and r is a 17-bit sum, so saturation is r[16].

## Timing
- Reset values:
  - State IDLE.
  - `in_ready`=1, `out_valid`=0, `out_uint`=0.
  - All flags 0.
  - acc and count are 0.
- Latency is counted in edges, including the accepting edge, up to the edge that raises `out_valid`:
  - Special case: 1.
  - Normal case: 24−e, ranging from 9 (e=15) to 25 (e=−1).
- Throughput: one result per (latency + 1) cycles minimum, because IDLE always lasts at least one cycle.
- Backpressure: DONE is held indefinitely while `out_ready`=0.
- If `out_ready` is already high when DONE is entered, the result is consumed on the next edge.
- Reset asserted mid-conversion: asynchronous return to the reset values on the asserting edge. The in-flight word is dropped and no `out_valid` pulse is produced.
- Reset release: the first acceptance can occur on the first edge after `resetn` rises.

## Test plan
- 1253.0 (0x449CA000), `out_ready`=1 → `out_uint`=1253, no flags, `out_valid` rises 14 edges after accept.
- 47.5 (0x423E0000) → 48 with ROUND_NEAREST=1, or 47 with 0. Latency 19.
- 0.5 (0x3F000000) → 1, latency 25. 0.49 (0x3EFAE148) → 0, latency 1.
- 70000.0 (0x4788B800) → 65535 + `out_saturated`, latency 1. 65535.75 (0x477FFFC0) → 65535 + `out_saturated` via the rounding overflow path, latency 9.
- −3.0 (0xC0400000) → 0 + `out_negative`. 0x7FC00000 → 0 + `out_nan`. 0x80000000 → 0 with no flags.
- 673.0 (0x44284000) with `out_ready`=0 for 20 cycles → `out_uint`=673 held stable and `in_ready`=0 throughout, then IDLE one edge after `out_ready`=1. Separately, pulse `resetn` low 5 edges into a conversion → all outputs return to reset values immediately and no stale `out_valid` appears.
